dmem_ctrl: RTL and testbench
============================

# dmem_ctrl

Data-memory controller directly downstream of the MEM stage. It accepts the MEM stage's word-addressed external-memory request (ext_mem_addr/wdata/write/read) and performs exactly one access per request on a synchronous single-port SRAM with configurable read latency. It returns registered read data and an ext_mem_ready handshake that the MEM stage forwards as mem_ready to stall the pipeline.

## Interface
Parameters:
- ADDR_W, 16, word-address width (matches ext_mem_addr)
- DATA_W, 32, data width
- DEPTH_WORDS, 16384, implemented SRAM words; legal addresses are 0..DEPTH_WORDS-1
- RD_LAT, 1, SRAM read latency in cycles; legal values are 1..4

Ports:
- clk  in  1  sole clock; all state updates on its rising edge
- rst  in  1  asynchronous, active-low reset (asserted when 0)
- ext_mem_addr  in  ADDR_W  word address from the MEM stage
- ext_mem_wdata  in  DATA_W  store data, already lane-shifted by the MEM stage
- ext_mem_write  in  1  store request (level)
- ext_mem_read  in  1  load request (level)
- ext_mem_rdata  out  DATA_W  registered load data
- ext_mem_ready  out  1  MEM-stage may advance
- ram_en  out  1  SRAM access strobe
- ram_we  out  1  SRAM write enable; qualified by ram_en
- ram_addr  out  ADDR_W  SRAM word address
- ram_wdata  out  DATA_W  SRAM write data
- ram_rdata  in  DATA_W  SRAM read data, valid RD_LAT cycles after the ram_en cycle
- err  out  1  sticky error flag

## Operation
- Request: req = ext_mem_read | ext_mem_write.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE
  - ext_mem_ready = !req (combinational).
  - If req is high, latch addr, wdata, kind (write wins if both are high) and range flag (addr >= DEPTH_WORDS), then go to ISSUE.
- ISSUE, one cycle
  - In range: ram_en=1, ram_we=kind, ram_addr and ram_wdata from the latches.
  - Out of range: ram_en=0; no SRAM access.
  - Write goes to DONE. Read loads the wait counter with RD_LAT and goes to WAIT.
- WAIT, RD_LAT cycles
  - The counter decrements each cycle.
  - In the last WAIT cycle, capture ram_rdata into ext_mem_rdata. For an out-of-range read, capture 32'h0.
  - Then go to DONE.
- DONE, one cycle
  - ext_mem_ready=1, then return to IDLE.
  - A req seen in the following IDLE cycle is a new request, including a repeat to the same address.
- The latched request is immune to input changes. A request dropped before DONE is still completed, and DONE is still pulsed.
- ext_mem_rdata holds its value until the next read capture. Writes never alter it.
- err is set, and stays set until reset, when any of these is latched in IDLE:
  - read and write both high;
  - an out-of-range address.
- ram_en and ram_we are 0 in every state except ISSUE. ram_addr and ram_wdata hold the latched values.

## Timing
- Cycle 0 is the IDLE cycle in which req is first high; ext_mem_ready=0 from cycle 0.
- Write: ram_en/ram_we high in cycle 1; ext_mem_ready pulses in cycle 2.
- Read: ram_en in cycle 1; WAIT in cycles 2..1+RD_LAT; ext_mem_ready pulses and ext_mem_rdata is valid in cycle 2+RD_LAT.
  - RD_LAT=1 gives ready in cycle 3; RD_LAT=2 gives cycle 4.
- Back-to-back: with a request in each IDLE cycle, writes complete every 3 cycles and reads every 3+RD_LAT cycles.
- Reset values, while rst=0: state=IDLE, ext_mem_ready=0, ext_mem_rdata=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, err=0, counter=0.
- Reset mid-operation:
  - The access is abandoned immediately and ram_en drops asynchronously.
  - A write in ISSUE while rst falls is not guaranteed to land; software must not rely on it.
  - No ready pulse is produced for the abandoned access.
  - After reset release, the first rising edge evaluates in IDLE.

## Structure
- Shared package dmem_pkg: state encoding (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, DONE=2'd3), default ADDR_W/DATA_W, RD_LAT_MAX=4.
- Counter width is 3 bits, sized from RD_LAT_MAX.
- Single module with no sub-module.
- The bench supplies a behavioural sram_model with the same ram_* ports and the RD_LAT parameter.

## Test plan
- Write then read, RD_LAT=1: write 0x00000010 = 32'hDEADBEEF at cycle 0, then read the same address.
  - ram_we is high in cycle 1 only; write ready at cycle 2.
  - Read ready 3 cycles after the read's cycle 0, with ext_mem_rdata=32'hDEADBEEF.
- RD_LAT=4 read: ext_mem_ready is low for cycles 0..5 and pulses in cycle 6 with correct data. ext_mem_rdata is unchanged by a following write.
- Request dropped and inputs changed: read 0x0020, then deassert read and change addr in cycle 1.
  - The access still reads 0x0020 and ready still pulses.
  - IDLE with no req shows ready=1.
- Boundary: read address 0x4000 with DEPTH_WORDS=16384.
  - ram_en stays 0 throughout.
  - ready pulses in cycle 2+RD_LAT with rdata=0.
  - err=1 and stays 1 across later legal accesses.
- Read and write both high on 0x0005 with wdata=32'h12345678: a write is performed, err=1, and a later read of 0x0005 returns 32'h12345678.
- Reset mid-operation: assert rst in WAIT of an RD_LAT=2 read.
  - All outputs reach their reset values without a clock edge.
  - No ready pulse occurs.
  - After release, a new write completes in 2 cycles.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: FSM encoding and sizing constants.
package dmem_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 32;
    localparam int RD_LAT_MAX = 4;
    localparam int CNT_W      = $clog2(RD_LAT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/dmem_ctrl.sv
// Data-memory controller: one SRAM access per MEM-stage request, with a ready
// handshake, registered load data and a sticky error flag.
//
// state | meaning
// IDLE  | waiting for a request; ready follows !req
// ISSUE | drive the SRAM strobe for the latched request
// WAIT  | count down the SRAM read latency, capture data on the last cycle
// DONE  | one-cycle ready pulse back to the MEM stage
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int          ADDR_W      = ADDR_W_DEF,
    parameter int          DATA_W      = DATA_W_DEF,
    parameter int unsigned DEPTH_WORDS = 16384,
    parameter int          RD_LAT      = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ext_mem_addr,
    input  logic [DATA_W-1:0] ext_mem_wdata,
    input  logic              ext_mem_write,
    input  logic              ext_mem_read,
    output logic [DATA_W-1:0] ext_mem_rdata,
    output logic              ext_mem_ready,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              err
);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               we_q, we_d;
    logic               oor_q, oor_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               err_q, err_d;
    logic               ready_c;
    logic               req;
    logic               oor_in;

    assign req    = ext_mem_read | ext_mem_write;
    assign oor_in = 32'(ext_mem_addr) >= DEPTH_WORDS;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            oor_q   <= 1'b0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            oor_q   <= oor_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = we_q;
        oor_d   = oor_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        ready_c = 1'b0;
        case (state_q)
            IDLE: begin
                ready_c = !req;
                if (req) begin
                    addr_d  = ext_mem_addr;
                    wdata_d = ext_mem_wdata;
                    we_d    = ext_mem_write;
                    oor_d   = oor_in;
                    if ((ext_mem_read && ext_mem_write) || oor_in) begin
                        err_d = 1'b1;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d = DONE;
                end else begin
                    cnt_d   = CNT_W'(RD_LAT);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                // Out-of-range loads never touched the SRAM, so return zero.
                if (cnt_q <= CNT_W'(1)) begin
                    rdata_d = oor_q ? '0 : ram_rdata;
                    state_d = DONE;
                end
            end
            DONE: begin
                ready_c = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Gate with reset so ready reads 0 while reset is held, not !req.
    assign ext_mem_ready = rst & ready_c;
    assign ram_en        = (state_q == ISSUE) & ~oor_q;
    assign ram_we        = ram_en & we_q;
    assign ram_addr      = addr_q;
    assign ram_wdata     = wdata_q;
    assign ext_mem_rdata = rdata_q;
    assign err           = err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl at read latencies 1, 2 and 4: directed and random requests
// scored against a queue-based reference model of memory, load data and error flag.
module sram_model #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16384,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              ram_en,
    input  logic              ram_we,
    input  logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_wdata,
    output logic [DATA_W-1:0] ram_rdata
);
    logic [DATA_W-1:0] mem  [DEPTH];
    logic [DATA_W-1:0] pipe [RD_LAT];

    initial begin
        foreach (mem[i]) mem[i] = '0;
        foreach (pipe[i]) pipe[i] = '0;
    end

    // Non-read cycles push a marker so a mistimed capture shows up as bad data.
    always @(posedge clk) begin
        if (ram_en && ram_we && int'(ram_addr) < DEPTH) mem[int'(ram_addr)] <= ram_wdata;
        if (ram_en && !ram_we && int'(ram_addr) < DEPTH) pipe[0] <= mem[int'(ram_addr)];
        else pipe[0] <= DATA_W'(32'hBAD0BAD0);
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end

    assign ram_rdata = pipe[RD_LAT-1];
endmodule

module tb_dmem_ctrl;
    import dmem_pkg::*;

    localparam int DEPTH = 16384;

    typedef struct { int cyc; logic [31:0] rdata; logic err; } exp_t;
    typedef struct { int cyc; logic we; logic [15:0] addr; logic [31:0] wdata; } acc_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic fail(input string name, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, what);
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 2 : 4);

        logic        rst_n, rd, wr, rdy, ram_en, ram_we, err;
        logic [15:0] addr, ram_addr;
        logic [31:0] wdata, rdata, ram_wdata, ram_rdata;
        int          cyc = 0;
        bit          done = 1'b0;
        logic        prev_rdy = 1'b1;
        exp_t        exp_q[$];
        acc_t        acc_q[$];
        logic [31:0] mem_m [int];
        logic        m_err;
        logic [31:0] m_rdata;

        dmem_ctrl #(
            .ADDR_W(16), .DATA_W(32), .DEPTH_WORDS(DEPTH), .RD_LAT(LAT)
        ) u_dut (
            .clk(clk), .rst(rst_n),
            .ext_mem_addr(addr), .ext_mem_wdata(wdata),
            .ext_mem_write(wr), .ext_mem_read(rd),
            .ext_mem_rdata(rdata), .ext_mem_ready(rdy),
            .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
            .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .err(err)
        );

        sram_model #(.ADDR_W(16), .DATA_W(32), .DEPTH(DEPTH), .RD_LAT(LAT)) u_ram (
            .clk(clk), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
            .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
        );

        always @(posedge clk) cyc <= cyc + 1;

        // Monitor: SRAM strobes against expected accesses, ready pulses against responses.
        always @(negedge clk) begin
            acc_t a;
            exp_t e;
            if (ram_en) begin
                if (acc_q.size() == 0) begin
                    fail($sformatf("L%0d ram_en", LAT), $sformatf("got strobe at cycle %0d, expected none", cyc));
                end else begin
                    a = acc_q.pop_front();
                    chk($sformatf("L%0d ram_cyc", LAT), 32'(cyc), 32'(a.cyc));
                    chk($sformatf("L%0d ram_we", LAT), 32'(ram_we), 32'(a.we));
                    chk($sformatf("L%0d ram_addr", LAT), 32'(ram_addr), 32'(a.addr));
                    if (a.we) chk($sformatf("L%0d ram_wdata", LAT), ram_wdata, a.wdata);
                end
            end
            if (ram_we && !ram_en) begin
                fail($sformatf("L%0d ram_we_qual", LAT), "got ram_we without ram_en, expected none");
            end
            if (rdy && !prev_rdy) begin
                if (exp_q.size() == 0) begin
                    fail($sformatf("L%0d ready", LAT), $sformatf("got ready pulse at cycle %0d, expected none", cyc));
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("L%0d done_cyc", LAT), 32'(cyc), 32'(e.cyc));
                    chk($sformatf("L%0d rdata", LAT), rdata, e.rdata);
                    chk($sformatf("L%0d err", LAT), 32'(err), 32'(e.err));
                end
            end
            prev_rdy = rdy | ~rst_n;
        end

        // Issue one request from an IDLE negedge; return at the IDLE negedge after DONE.
        task automatic do_op(input logic r, input logic w, input logic [15:0] a, input logic [31:0] d);
            logic oor;
            int   n;
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            chk($sformatf("L%0d idle_ready", LAT), 32'(rdy), 32'd1);
            #1;
            rd = r; wr = w; addr = a; wdata = d;
            oor = (int'(a) >= DEPTH);
            if ((r && w) || oor) m_err = 1'b1;
            if (w) begin
                if (!oor) mem_m[int'(a)] = d;
            end else begin
                m_rdata = oor ? 32'h0 : (mem_m.exists(int'(a)) ? mem_m[int'(a)] : 32'h0);
            end
            if (!oor) acc_q.push_back('{cyc + 1, w, a, d});
            exp_q.push_back('{cyc + (w ? 2 : 2 + LAT), m_rdata, m_err});
            @(negedge clk); #1;
            rd = 1'b0; wr = 1'b0; addr = 16'($urandom); wdata = $urandom;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!rdy && n < 20);
            if (!rdy) fail($sformatf("L%0d timeout", LAT), "got no ready within 20 cycles, expected a pulse");
            @(negedge clk);
        endtask

        initial begin
            logic [15:0] ra;
            int          k;
            rst_n = 1'b0; rd = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
            m_err = 1'b0; m_rdata = '0;
            repeat (3) @(negedge clk);
            chk($sformatf("L%0d rst_ready", LAT), 32'(rdy), 32'd0);
            chk($sformatf("L%0d rst_rdata", LAT), rdata, 32'd0);
            chk($sformatf("L%0d rst_err", LAT), 32'(err), 32'd0);
            chk($sformatf("L%0d rst_ram_en", LAT), 32'(ram_en), 32'd0);
            #1 rst_n = 1'b1;
            @(negedge clk);

            do_op(1'b0, 1'b1, 16'h0010, 32'hDEADBEEF);
            do_op(1'b1, 1'b0, 16'h0010, 32'h0);
            do_op(1'b0, 1'b1, 16'h0011, 32'hA5A50001);
            do_op(1'b1, 1'b0, 16'h0020, 32'h0);
            do_op(1'b1, 1'b0, 16'h3FFF, 32'h0);
            do_op(1'b1, 1'b0, 16'h4000, 32'h0);
            do_op(1'b0, 1'b1, 16'h0020, 32'h0BADF00D);
            do_op(1'b1, 1'b1, 16'h0005, 32'h12345678);
            do_op(1'b1, 1'b0, 16'h0005, 32'h0);
            do_op(1'b0, 1'b1, 16'hFFFF, 32'h55555555);
            do_op(1'b1, 1'b0, 16'h0010, 32'h0);

            for (int i = 0; i < 40; i++) begin
                ra = ($urandom_range(0, 7) == 0) ? 16'(32'h4000 + $urandom_range(0, 32'hBFFF))
                                                 : 16'($urandom_range(0, 15));
                k  = $urandom_range(0, 9);
                do_op(k >= 4, (k < 4) || (k == 9), ra, $urandom);
            end

            // Reset in the middle of a read's WAIT phase.
            #1;
            rd = 1'b1; addr = 16'h0010;
            acc_q.push_back('{cyc + 1, 1'b0, 16'h0010, 32'h0});
            @(negedge clk); #1;
            rd = 1'b0;
            @(negedge clk);
            #1 rst_n = 1'b0;
            #1;
            chk($sformatf("L%0d arst_ready", LAT), 32'(rdy), 32'd0);
            chk($sformatf("L%0d arst_rdata", LAT), rdata, 32'd0);
            chk($sformatf("L%0d arst_ram_en", LAT), 32'(ram_en), 32'd0);
            chk($sformatf("L%0d arst_ram_we", LAT), 32'(ram_we), 32'd0);
            chk($sformatf("L%0d arst_ram_addr", LAT), 32'(ram_addr), 32'd0);
            chk($sformatf("L%0d arst_ram_wdata", LAT), ram_wdata, 32'd0);
            chk($sformatf("L%0d arst_err", LAT), 32'(err), 32'd0);
            m_err = 1'b0; m_rdata = '0;
            repeat (LAT + 3) begin
                @(negedge clk);
                chk($sformatf("L%0d arst_no_ready", LAT), 32'(rdy), 32'd0);
            end
            #1 rst_n = 1'b1;
            @(negedge clk);
            do_op(1'b0, 1'b1, 16'h0030, 32'hCAFE0001);
            do_op(1'b1, 1'b0, 16'h0030, 32'h0);
            chk($sformatf("L%0d exp_q_empty", LAT), 32'(exp_q.size()), 32'd0);
            chk($sformatf("L%0d acc_q_empty", LAT), 32'(acc_q.size()), 32'd0);
            done = 1'b1;
        end
    end

    initial begin
        int t;
        t = 0;
        while (!(g_inst[0].done && g_inst[1].done && g_inst[2].done) && t < 20000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 20000) fail("global_timeout", "got unfinished drivers, expected all done");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
